coin_dispenser: RTL and testbench

COIN_DISPENSER -- requirements
Module: coin_dispenser

---
 rtl/coin_dispenser_pkg.sv | 21 ++
 rtl/coin_dispenser.sv | 127 ++++++++++++
 tb/tb_coin_dispenser.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_dispenser_pkg.sv
// Shared coin codes and payout FSM state encoding for the coin dispenser and the vending FSM.
package coin_dispenser_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_FIVE = 2'b01,
    COIN_TEN  = 2'b10
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SELECT = 2'b01,
    ST_ISSUE  = 2'b10,
    ST_FINISH = 2'b11
  } state_e;

  // Payout units are 5-unit steps; a ten is worth two steps.
  localparam logic [3:0] TEN_STEPS  = 4'd2;
  localparam logic [3:0] FIVE_STEPS = 4'd1;

endpackage

// File: rtl/coin_dispenser.sv
// Greedy coin payout: tens first, then fives; first coin two cycles after req, one coin per
// ISSUE visit held stable until coin_ack, so at most one coin every two cycles.
module coin_dispenser
  import coin_dispenser_pkg::*;
#(
  parameter int unsigned INIT_FIVES = 8,
  parameter int unsigned INIT_TENS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] amount,
  input  logic       refill,
  output logic [1:0] coin,
  output logic       coin_valid,
  input  logic       coin_ack,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [3:0] unpaid,
  output logic [3:0] fives_cnt,
  output logic [3:0] tens_cnt
);

  localparam logic [3:0] INIT_F = INIT_FIVES[3:0];
  localparam logic [3:0] INIT_T = INIT_TENS[3:0];

  state_e     state_q, state_d;
  coin_e      coin_q, coin_d;
  logic [3:0] remaining_q, remaining_d;
  logic [3:0] fives_q, fives_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] unpaid_q, unpaid_d;
  logic       short_q, short_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      coin_q      <= COIN_NONE;
      remaining_q <= 4'd0;
      fives_q     <= INIT_F;
      tens_q      <= INIT_T;
      unpaid_q    <= 4'd0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      coin_q      <= coin_d;
      remaining_q <= remaining_d;
      fives_q     <= fives_d;
      tens_q      <= tens_d;
      unpaid_q    <= unpaid_d;
      short_q     <= short_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    coin_d      = coin_q;
    remaining_d = remaining_q;
    fives_d     = fives_q;
    tens_d      = tens_q;
    unpaid_d    = unpaid_q;
    short_d     = short_q;

    case (state_q)
      ST_IDLE: begin
        // Refill wins over req so a restock never overlaps a payout.
        if (refill) begin
          fives_d = INIT_F;
          tens_d  = INIT_T;
        end else if (req) begin
          remaining_d = amount;
          short_d     = 1'b0;
          unpaid_d    = 4'd0;
          state_d     = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (remaining_q >= TEN_STEPS && tens_q != 4'd0) begin
          coin_d  = COIN_TEN;
          state_d = ST_ISSUE;
        end else if (remaining_q != 4'd0 && fives_q != 4'd0) begin
          coin_d  = COIN_FIVE;
          state_d = ST_ISSUE;
        end else begin
          // Short/unpaid are registered here so they are already valid alongside done.
          short_d  = (remaining_q != 4'd0);
          unpaid_d = remaining_q;
          state_d  = ST_FINISH;
        end
      end

      ST_ISSUE: begin
        if (coin_ack) begin
          if (coin_q == COIN_TEN) begin
            remaining_d = remaining_q - TEN_STEPS;
            tens_d      = tens_q - 4'd1;
          end else begin
            remaining_d = remaining_q - FIVE_STEPS;
            fives_d     = fives_q - 4'd1;
          end
          coin_d  = COIN_NONE;
          state_d = ST_SELECT;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign coin_valid = (state_q == ST_ISSUE);
  assign coin       = coin_valid ? coin_q : COIN_NONE;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);
  assign short      = short_q;
  assign unpaid     = unpaid_q;
  assign fives_cnt  = fives_q;
  assign tens_cnt   = tens_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Scoreboard bench: stimulus queues expected coins and done records; a negedge monitor pops them.
module tb_coin_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [3:0] amount = 4'd0;
  logic       refill = 1'b0;
  logic [1:0] coin;
  logic       coin_valid;
  logic       coin_ack = 1'b0;
  logic       busy;
  logic       done;
  logic       short;
  logic [3:0] unpaid;
  logic [3:0] fives_cnt;
  logic [3:0] tens_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_done;
    logic [1:0] coin;
    logic       shrt;
    logic [3:0] unpaid;
    logic [3:0] fives;
    logic [3:0] tens;
  } exp_t;

  exp_t exp_q[$];

  coin_dispenser #(.INIT_FIVES(8), .INIT_TENS(8)) dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount), .refill(refill),
    .coin(coin), .coin_valid(coin_valid), .coin_ack(coin_ack), .busy(busy),
    .done(done), .short(short), .unpaid(unpaid), .fives_cnt(fives_cnt), .tens_cnt(tens_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_coin(input logic [1:0] c);
    exp_t e;
    e = '{is_done: 1'b0, coin: c, shrt: 1'b0, unpaid: 4'd0, fives: 4'd0, tens: 4'd0};
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic s, input logic [3:0] u, input logic [3:0] f, input logic [3:0] t);
    exp_t e;
    e = '{is_done: 1'b1, coin: 2'b00, shrt: s, unpaid: u, fives: f, tens: t};
    exp_q.push_back(e);
  endtask

  // Monitor: an accepted coin is coin_valid && coin_ack in the same cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (!coin_valid) check("coin_idle_zero", 32'(coin), 32'd0);
      if (coin_valid && coin_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_coin", 32'(coin), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("coin_kind_is_coin", 32'(e.is_done), 32'd0);
          check("coin_code", 32'(coin), 32'(e.coin));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind_is_done", 32'(e.is_done), 32'd1);
          check("done_short", 32'(short), 32'(e.shrt));
          check("done_unpaid", 32'(unpaid), 32'(e.unpaid));
          check("done_fives", 32'(fives_cnt), 32'(e.fives));
          check("done_tens", 32'(tens_cnt), 32'(e.tens));
          check("done_coin_valid_low", 32'(coin_valid), 32'd0);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    refill = 1'b0;
    coin_ack = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Returns one cycle after the req edge; amount is scrambled to prove it was captured.
  task automatic start_req(input logic [3:0] amt);
    req = 1'b1;
    amount = amt;
    cycle();
    req = 1'b0;
    amount = ~amt;
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        seen = 1'b1;
        break;
      end
      cycle();
    end
    if (!seen) check({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_coin_valid", 32'(coin_valid), 32'd0);
    check("rst_coin", 32'(coin), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_short", 32'(short), 32'd0);
    check("rst_unpaid", 32'(unpaid), 32'd0);
    check("rst_fives", 32'(fives_cnt), 32'd8);
    check("rst_tens", 32'(tens_cnt), 32'd8);

    // amount=3, immediate acks: TEN then FIVE
    coin_ack = 1'b1;
    push_coin(2'b10);
    push_coin(2'b01);
    push_done(1'b0, 4'd0, 4'd7, 4'd7);
    start_req(4'd3);
    check("lat_busy_k1", 32'(busy), 32'd1);
    check("lat_cv_k1", 32'(coin_valid), 32'd0);
    cycle();
    check("lat_cv_k2", 32'(coin_valid), 32'd1);
    check("lat_coin_k2", 32'(coin), 32'd2);
    wait_idle("pay3");

    // amount=0: done in cycle k+2, no coin
    do_reset();
    coin_ack = 1'b0;
    push_done(1'b0, 4'd0, 4'd8, 4'd8);
    start_req(4'd0);
    check("zero_done_k1", 32'(done), 32'd0);
    check("zero_busy_k1", 32'(busy), 32'd1);
    cycle();
    check("zero_done_k2", 32'(done), 32'd1);
    check("zero_cv_k2", 32'(coin_valid), 32'd0);
    wait_idle("pay0");
    check("zero_fives", 32'(fives_cnt), 32'd8);

    // Delayed ack: coin held stable, inventory untouched until the ack edge
    do_reset();
    push_coin(2'b01);
    push_done(1'b0, 4'd0, 4'd7, 4'd8);
    start_req(4'd1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_cv", 32'(coin_valid), 32'd1);
      check("hold_coin", 32'(coin), 32'd1);
      check("hold_fives", 32'(fives_cnt), 32'd8);
    end
    cycle();
    coin_ack = 1'b1;
    cycle();
    coin_ack = 1'b0;
    check("hold_fives_after_ack", 32'(fives_cnt), 32'd7);
    wait_idle("hold");

    // Two payouts of 15 drain the tens, then run short
    do_reset();
    coin_ack = 1'b1;
    for (int i = 0; i < 7; i++) push_coin(2'b10);
    push_coin(2'b01);
    push_done(1'b0, 4'd0, 4'd7, 4'd1);
    start_req(4'd15);
    wait_idle("drain1");
    push_coin(2'b10);
    for (int i = 0; i < 7; i++) push_coin(2'b01);
    push_done(1'b1, 4'd6, 4'd0, 4'd0);
    start_req(4'd15);
    wait_idle("drain2");
    check("drain_short_held", 32'(short), 32'd1);
    check("drain_unpaid_held", 32'(unpaid), 32'd6);

    // Refill with req in IDLE: reload only, no payout
    refill = 1'b1;
    req = 1'b1;
    amount = 4'd5;
    cycle();
    refill = 1'b0;
    req = 1'b0;
    check("refill_busy", 32'(busy), 32'd0);
    check("refill_fives", 32'(fives_cnt), 32'd8);
    check("refill_tens", 32'(tens_cnt), 32'd8);
    cycle();
    check("refill_busy_later", 32'(busy), 32'd0);

    // Reset while a coin is presented
    do_reset();
    coin_ack = 1'b0;
    start_req(4'd2);
    cycle();
    check("midrst_cv_before", 32'(coin_valid), 32'd1);
    rst = 1'b1;
    cycle();
    check("midrst_cv", 32'(coin_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_fives", 32'(fives_cnt), 32'd8);
    check("midrst_tens", 32'(tens_cnt), 32'd8);
    rst = 1'b0;
    repeat (4) cycle();
    check("midrst_stays_idle", 32'(busy), 32'd0);

    // req and refill while busy are ignored
    do_reset();
    coin_ack = 1'b1;
    push_coin(2'b10);
    push_coin(2'b10);
    push_done(1'b0, 4'd0, 4'd8, 4'd6);
    start_req(4'd4);
    cycle();
    refill = 1'b1;
    req = 1'b1;
    amount = 4'd15;
    cycle();
    refill = 1'b0;
    req = 1'b0;
    wait_idle("busy_ignore");
    cycle();
    check("busy_ignore_idle", 32'(busy), 32'd0);
    check("busy_ignore_tens", 32'(tens_cnt), 32'd6);

    repeat (3) cycle();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
